param_sync_fifo: RTL and testbench
==================================

Name: param_sync_fifo

Overview:
Single-clock, parametrised successor to the team's mixed-clock FIFO, used between polynomial-evaluator pipeline stages that share one clock.
- Uses all CAPACITY entries; full is asserted at CAPACITY, not CAPACITY-1.
- Supports non-power-of-two depth.
- Provides occupancy count, programmable almost-full/almost-empty flags, a registered read-valid strobe and sticky overflow/underflow error flags.

Parameters:
DATA_WIDTH, 8, width of each data word
CAPACITY, 8, number of storage entries (>=2, any integer)
PTR_WIDTH, 3, pointer width; must equal ceil(log2(CAPACITY))
CNT_WIDTH, 4, count width; must equal ceil(log2(CAPACITY+1))
AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  DATA_WIDTH  write data
w_en  input  1  write request
r_en  input  1  read request
err_clr  input  1  synchronous clear of overflow/underflow
out_data  output  DATA_WIDTH  read data, registered
out_valid  output  1  out_data holds a newly popped word this cycle
full  output  1  count == CAPACITY
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  CNT_WIDTH  current occupancy
overflow  output  1  sticky: write attempted while refused
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (reset=0, asynchronous): r_ptr=0, w_ptr=0, count=0, out_data=0, out_valid=0, overflow=0, underflow=0. Memory contents are not reset. With count=0: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
- Reset asserted mid-operation discards all stored words immediately; first rising edge after release behaves as from reset.
- Read accept: rd_ok = r_en && !empty.
- Write accept: wr_ok = w_en && (!full || rd_ok). A write while full is accepted only when a read is accepted in the same cycle.
- Write on wr_ok: memory[w_ptr] <= in_data; w_ptr advances.
- Read on rd_ok: out_data <= memory[r_ptr]; r_ptr advances; out_valid <= 1.
- Read latency: 1 cycle; data appears the cycle after the r_en edge.
- No read this cycle: out_valid <= 0 and out_data holds its previous value. Out_data is not zeroed.
- Same-cycle read and write at the same address (full case): the read returns the old word.
- Empty: no write-to-read bypass. A read while empty is refused even if a write happens in the same cycle.
- Pointer wrap: a pointer equal to CAPACITY-1 advances to 0, so non-power-of-two depths work. A pointer never takes a value >= CAPACITY.
- count update:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged when both or neither
  - always 0..CAPACITY
- full, empty, almost_full and almost_empty are combinational decodes of the registered count. They reflect state after the most recent edge.
- Error flags:
  - overflow <= 1 when w_en && !wr_ok
  - underflow <= 1 when r_en && empty
  - Both are sticky until err_clr=1 or reset.
  - If err_clr and a new error occur in the same cycle, the set wins.
- A refused access changes no pointer, count or memory.

Decomposition:
- Shared package/header holds:
  - the ceil-log2 constant function used to derive PTR_WIDTH and CNT_WIDTH
  - the default DATA_WIDTH/CAPACITY constants shared with the evaluator datapath
- One sub-module: fifo_wrap_counter (parametrised WIDTH and MODULUS; increment-enable; wraps at MODULUS-1; async active-low reset to 0).
- fifo_wrap_counter is instantiated twice, for r_ptr and w_ptr.
- Count, flags and memory stay in the top module.

Test Plan:
1. Reset, then write 0x11..0x18 (8 writes, CAPACITY=8, no reads) -> count=8, full=1, almost_full=1 from the 6th write. A 9th write sets overflow=1; count stays 8.
2. Drain 8 reads -> out_data 0x11..0x18 in order, each with out_valid=1 one cycle after its r_en. empty=1 after the last read. A further r_en sets underflow=1 with out_valid=0.
3. CAPACITY=5, PTR_WIDTH=3, CNT_WIDTH=3: stream 12 words with interleaved reads -> order preserved across wrap; w_ptr and r_ptr never exceed 4.
4. Fill to full, then assert w_en=r_en=1 with in_data=0xAA -> oldest word read out, 0xAA accepted, count stays 8, overflow stays 0.
5. Empty FIFO, w_en=r_en=1 with 0x55 -> write accepted, read refused, count=1, underflow=1. Next cycle err_clr=1 -> underflow=0.
6. Load 4 words, assert reset low asynchronously between edges -> count=0, empty=1, out_valid=0 immediately. After release, a write of 0x33 then a read returns 0x33.

Source files
------------

// File: rtl/param_sync_fifo_pkg.sv
`default_nettype none
// param_sync_fifo_pkg: width helper and default sizing shared with the evaluator datapath.
// Rev 1.0
package param_sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CAPACITY   = 8;

  // Smallest n with 2**n >= value; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/param_sync_fifo_wrap_counter.sv
`default_nettype none
// fifo_wrap_counter: modulo-MODULUS up-counter used as a FIFO read/write pointer.
// Rev 1.0
module fifo_wrap_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] value_o
);

  localparam logic [WIDTH-1:0] C_LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Explicit wrap keeps non-power-of-two moduli inside 0..MODULUS-1.
  always_comb begin
    value_d = value_q;
    if (inc_i) begin
      value_d = (value_q == C_LAST) ? '0 : value_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule
`default_nettype wire

// File: rtl/param_sync_fifo.sv
`default_nettype none
// param_sync_fifo: single-clock FIFO using all CAPACITY entries, with occupancy flags and sticky errors.
// Rev 1.0
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CAPACITY   = DEFAULT_CAPACITY,
  parameter int PTR_WIDTH  = clog2(CAPACITY),
  parameter int CNT_WIDTH  = clog2(CAPACITY + 1),
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [CNT_WIDTH-1:0] C_FULL = CNT_WIDTH'(CAPACITY);

  logic [DATA_WIDTH-1:0] mem_q [CAPACITY];
  logic [PTR_WIDTH-1:0]  w_ptr;
  logic [PTR_WIDTH-1:0]  r_ptr;

  logic [CNT_WIDTH-1:0]  count_q,     count_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overflow_q,  overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_ok;
  logic                  wr_ok;

  assign empty        = (count_q == '0);
  assign full         = (count_q == C_FULL);
  assign almost_full  = (32'(count_q) >= 32'(AF_LEVEL));
  assign almost_empty = (32'(count_q) <= 32'(AE_LEVEL));

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    rd_ok       = r_en && !empty;
    wr_ok       = w_en && (!full || rd_ok);

    count_d     = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CNT_WIDTH'(1);
    end

    out_valid_d = rd_ok;
    out_data_d  = rd_ok ? mem_q[r_ptr] : out_data_q;

    // A new error in the same cycle as err_clr leaves the flag set.
    overflow_d  = (w_en && !wr_ok) ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
    underflow_d = (r_en && empty)  ? 1'b1 : (err_clr ? 1'b0 : underflow_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[w_ptr] <= in_data;
    end
  end

  fifo_wrap_counter #(
    .WIDTH   (PTR_WIDTH),
    .MODULUS (CAPACITY)
  ) u_w_ptr (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (wr_ok),
    .value_o (w_ptr)
  );

  fifo_wrap_counter #(
    .WIDTH   (PTR_WIDTH),
    .MODULUS (CAPACITY)
  ) u_r_ptr (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (rd_ok),
    .value_o (r_ptr)
  );

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// tb_param_sync_fifo: directed + randomized checks of two FIFO instances against a queue model.
// Rev 1.0
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a_din, b_din;
  logic       a_w, a_r, a_clr, b_w, b_r, b_clr;

  logic [7:0] a_out, b_out;
  logic       a_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic       b_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [3:0] a_cnt;
  logic [2:0] b_cnt;

  always #5 clk = ~clk;

  param_sync_fifo #(
    .DATA_WIDTH(8), .CAPACITY(8), .PTR_WIDTH(3), .CNT_WIDTH(4), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut_a (
    .clk(clk), .reset(reset), .in_data(a_din), .w_en(a_w), .r_en(a_r), .err_clr(a_clr),
    .out_data(a_out), .out_valid(a_valid), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt), .overflow(a_ovf), .underflow(a_unf)
  );

  param_sync_fifo #(
    .DATA_WIDTH(8), .CAPACITY(5), .PTR_WIDTH(3), .CNT_WIDTH(3), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut_b (
    .clk(clk), .reset(reset), .in_data(b_din), .w_en(b_w), .r_en(b_r), .err_clr(b_clr),
    .out_data(b_out), .out_valid(b_valid), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf), .underflow(b_unf)
  );

  // Reference model: one queue per instance plus expected registered outputs.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic [7:0] exp_out   [2];
  bit         exp_valid [2];
  bit         exp_ovf   [2];
  bit         exp_unf   [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic void model_reset();
    mq0.delete();
    mq1.delete();
    for (int k = 0; k < 2; k++) begin
      exp_out[k] = 8'h00; exp_valid[k] = 1'b0; exp_ovf[k] = 1'b0; exp_unf[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(input int k, input bit w, input bit r, input bit clr,
                                     input logic [7:0] d);
    int cap;
    int sz;
    bit rd_ok;
    bit wr_ok;
    cap   = (k == 0) ? 8 : 5;
    sz    = (k == 0) ? mq0.size() : mq1.size();
    rd_ok = r && (sz > 0);
    wr_ok = w && ((sz < cap) || rd_ok);
    exp_valid[k] = rd_ok;
    if (rd_ok) exp_out[k] = (k == 0) ? mq0.pop_front() : mq1.pop_front();
    if (wr_ok) begin
      if (k == 0) mq0.push_back(d);
      else        mq1.push_back(d);
    end
    if (w && !wr_ok) exp_ovf[k] = 1'b1;
    else if (clr)    exp_ovf[k] = 1'b0;
    if (r && sz == 0) exp_unf[k] = 1'b1;
    else if (clr)     exp_unf[k] = 1'b0;
  endfunction

  task automatic check_state(input int k);
    int sz, cap, af, ae;
    string p;
    logic [31:0] o_cnt, o_out;
    logic o_valid, o_full, o_empty, o_af, o_ae, o_ovf, o_unf;
    if (k == 0) begin
      sz = mq0.size(); cap = 8; af = 6; ae = 2; p = "a";
      o_cnt = 32'(a_cnt); o_out = 32'(a_out); o_valid = a_valid; o_full = a_full;
      o_empty = a_empty; o_af = a_af; o_ae = a_ae; o_ovf = a_ovf; o_unf = a_unf;
    end else begin
      sz = mq1.size(); cap = 5; af = 4; ae = 1; p = "b";
      o_cnt = 32'(b_cnt); o_out = 32'(b_out); o_valid = b_valid; o_full = b_full;
      o_empty = b_empty; o_af = b_af; o_ae = b_ae; o_ovf = b_ovf; o_unf = b_unf;
    end
    check({p, "_count"},        o_cnt,   sz);
    check({p, "_full"},         o_full,  sz == cap);
    check({p, "_empty"},        o_empty, sz == 0);
    check({p, "_almost_full"},  o_af,    sz >= af);
    check({p, "_almost_empty"}, o_ae,    sz <= ae);
    check({p, "_out_valid"},    o_valid, exp_valid[k]);
    check({p, "_out_data"},     o_out,   exp_out[k]);
    check({p, "_overflow"},     o_ovf,   exp_ovf[k]);
    check({p, "_underflow"},    o_unf,   exp_unf[k]);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0, a_w, a_r, a_clr, a_din);
    model_step(1, b_w, b_r, b_clr, b_din);
    #1;
    check_state(0);
    check_state(1);
    check("b_wptr_range", 32'(dut_b.w_ptr <= 3'd4), 32'd1);
    check("b_rptr_range", 32'(dut_b.r_ptr <= 3'd4), 32'd1);
  endtask

  task automatic idle_inputs();
    a_w = 0; a_r = 0; a_clr = 0; a_din = 8'h00;
    b_w = 0; b_r = 0; b_clr = 0; b_din = 8'h00;
  endtask

  initial begin
    int rd_idx;
    int wprob;
    int rprob;
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #2;
    check_state(0);
    check_state(1);
    #10 reset = 1'b1;

    // Fill to capacity, then one refused write.
    for (int i = 0; i < 8; i++) begin
      a_w = 1; a_din = 8'h11 + 8'(i);
      step();
    end
    a_din = 8'h19;
    step();
    check("t1_count_after_ovf", 32'(a_cnt), 32'd8);
    check("t1_overflow", 32'(a_ovf), 32'd1);
    a_w = 0;

    // Drain in order, then a read on empty.
    a_r = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t2_order", 32'(a_out), 32'h11 + 32'(i));
      check("t2_valid", 32'(a_valid), 32'd1);
    end
    step();
    check("t2_underflow", 32'(a_unf), 32'd1);
    check("t2_no_valid", 32'(a_valid), 32'd0);
    a_r = 0; a_clr = 1;
    step();
    a_clr = 0;

    // Full with simultaneous read and write.
    for (int i = 0; i < 8; i++) begin
      a_w = 1; a_din = 8'h21 + 8'(i);
      step();
    end
    a_r = 1; a_din = 8'hAA;
    step();
    check("t4_oldest_out", 32'(a_out), 32'h21);
    check("t4_count", 32'(a_cnt), 32'd8);
    check("t4_no_ovf", 32'(a_ovf), 32'd0);
    a_w = 0;
    for (int i = 0; i < 8; i++) step();
    check("t4_last_is_aa", 32'(a_out), 32'hAA);
    a_r = 0;

    // Empty with simultaneous read and write: no bypass.
    a_w = 1; a_r = 1; a_din = 8'h55;
    step();
    check("t5_count", 32'(a_cnt), 32'd1);
    check("t5_underflow", 32'(a_unf), 32'd1);
    a_w = 0; a_r = 0; a_clr = 1;
    step();
    check("t5_unf_cleared", 32'(a_unf), 32'd0);
    a_clr = 0; a_r = 1;
    step();
    check("t5_read_55", 32'(a_out), 32'h55);
    a_r = 0;

    // Non-power-of-two depth streaming across pointer wrap.
    rd_idx = 0;
    for (int i = 0; i < 30; i++) begin
      b_w   = (i < 24) && (i % 2 == 0);
      b_din = 8'h40 + 8'(i / 2);
      b_r   = (i >= 3) && (i % 2 == 1);
      step();
      if (b_valid === 1'b1) begin
        check("t3_order", 32'(b_out), 32'h40 + 32'(rd_idx));
        rd_idx++;
      end
    end
    check("t3_all_read", rd_idx, 12);
    b_w = 0; b_r = 0;

    // Asynchronous reset mid-cycle with data stored and a valid read pending.
    for (int i = 0; i < 4; i++) begin
      a_w = 1; a_din = 8'h60 + 8'(i);
      step();
    end
    a_w = 0; a_r = 1;
    step();
    a_r = 0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("t6_count_now", 32'(a_cnt), 32'd0);
    check("t6_empty_now", 32'(a_empty), 32'd1);
    check("t6_valid_now", 32'(a_valid), 32'd0);
    check_state(0);
    check_state(1);
    #1 reset = 1'b1;
    a_w = 1; a_din = 8'h33;
    step();
    a_w = 0; a_r = 1;
    step();
    check("t6_read_33", 32'(a_out), 32'h33);
    a_r = 0;

    // Randomized traffic with shifting write/read bias.
    for (int ph = 0; ph < 8; ph++) begin
      wprob = (ph % 2 == 0) ? 75 : 30;
      rprob = (ph % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 50; i++) begin
        a_w   = ($urandom_range(0, 99) < wprob);
        a_r   = ($urandom_range(0, 99) < rprob);
        a_clr = ($urandom_range(0, 7) == 0);
        a_din = 8'($urandom);
        b_w   = ($urandom_range(0, 99) < wprob);
        b_r   = ($urandom_range(0, 99) < rprob);
        b_clr = ($urandom_range(0, 7) == 0);
        b_din = 8'($urandom);
        step();
      end
    end
    idle_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
